// File: rtl/i2c_scl_gen.sv
// rtl/i2c_scl_gen.sv - runtime-programmable I2C SCL generator with stretch detect and phase strobes
// Optional stretch timeout: define I2C_SCL_STRETCH_TIMEOUT_EN.
module i2c_scl_gen #(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic             ref_clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [CNT_W-1:0] half_period,
  input  logic             scl_in,
  output logic             scl_out,
  output logic             scl_fall_stb,
  output logic             scl_rise_stb,
  output logic             drive_stb,
  output logic             sample_stb,
  output logic             stretching,
  output logic             busy,
  output logic             timeout
);

  typedef enum logic [1:0] {IDLE, LOW, WAIT_HIGH, HIGH} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hl;
  logic [CNT_W-1:0] hl_new;
  logic [CNT_W-1:0] hl_half;
  logic [CNT_W-1:0] hl_last;
  logic [CNT_W-1:0] cnt_inc;

  // Half periods below 4 would collapse the mid-phase strobes onto the edges.
  assign hl_new  = (half_period < CNT_W'(4)) ? CNT_W'(4) : half_period;
  assign hl_half = hl >> 1;
  assign hl_last = hl - 1'b1;
  assign cnt_inc = cnt + 1'b1;

`ifdef I2C_SCL_STRETCH_TIMEOUT_EN
  logic        timeout_q;
  logic [31:0] stretch_cnt;
  assign timeout = timeout_q;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge ref_clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      hl           <= CNT_W'(4);
      scl_out      <= 1'b1;
      scl_fall_stb <= 1'b0;
      scl_rise_stb <= 1'b0;
      drive_stb    <= 1'b0;
      sample_stb   <= 1'b0;
      stretching   <= 1'b0;
      busy         <= 1'b0;
`ifdef I2C_SCL_STRETCH_TIMEOUT_EN
      timeout_q    <= 1'b0;
      stretch_cnt  <= '0;
`endif
    end else begin
      scl_fall_stb <= 1'b0;
      scl_rise_stb <= 1'b0;
      drive_stb    <= 1'b0;
      sample_stb   <= 1'b0;
      case (state)
        IDLE: begin
          scl_out    <= 1'b1;
          stretching <= 1'b0;
          cnt        <= '0;
`ifdef I2C_SCL_STRETCH_TIMEOUT_EN
          if (!enable) timeout_q <= 1'b0;
          if (enable && !timeout_q) begin
`else
          if (enable) begin
`endif
            state        <= LOW;
            scl_out      <= 1'b0;
            hl           <= hl_new;
            scl_fall_stb <= 1'b1;
            busy         <= 1'b1;
          end
        end
        LOW: begin
          if (cnt == hl_last) begin
            state   <= WAIT_HIGH;
            scl_out <= 1'b1;
            cnt     <= '0;
`ifdef I2C_SCL_STRETCH_TIMEOUT_EN
            stretch_cnt <= '0;
`endif
          end else begin
            cnt       <= cnt_inc;
            drive_stb <= (cnt_inc == hl_half);
          end
        end
        WAIT_HIGH: begin
          if (scl_in) begin
            state        <= HIGH;
            cnt          <= '0;
            scl_rise_stb <= 1'b1;
            stretching   <= 1'b0;
`ifdef I2C_SCL_STRETCH_TIMEOUT_EN
          end else if (stretch_cnt == 32'(TIMEOUT_CYC - 1)) begin
            state      <= IDLE;
            busy       <= 1'b0;
            stretching <= 1'b0;
            timeout_q  <= 1'b1;
          end else begin
            stretch_cnt <= stretch_cnt + 1'b1;
            stretching  <= 1'b1;
          end
`else
          end else begin
            stretching <= 1'b1;
          end
`endif
        end
        HIGH: begin
          if (cnt == hl_last) begin
            // Re-sampled enable here lets back-to-back cycles run with no idle gap.
            if (enable) begin
              state        <= LOW;
              scl_out      <= 1'b0;
              cnt          <= '0;
              hl           <= hl_new;
              scl_fall_stb <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              cnt   <= '0;
            end
          end else begin
            cnt        <= cnt_inc;
            sample_stb <= (cnt_inc == hl_half);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_scl_gen.sv
// tb/tb_i2c_scl_gen.sv - scoreboard bench for i2c_scl_gen
module tb_i2c_scl_gen;

  logic        ref_clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        hold_low;
  logic [15:0] half_period;
  logic        scl_in;
  logic        scl_out, scl_fall_stb, scl_rise_stb, drive_stb, sample_stb;
  logic        stretching, busy, timeout;

  always #5 ref_clk = ~ref_clk;

  // Open-drain loopback; hold_low models a slave stretching the clock.
  assign scl_in = scl_out & ~hold_low;

  i2c_scl_gen #(.CNT_W(16), .TIMEOUT_CYC(64)) dut (
    .ref_clk(ref_clk), .reset(reset), .enable(enable), .half_period(half_period),
    .scl_in(scl_in), .scl_out(scl_out), .scl_fall_stb(scl_fall_stb),
    .scl_rise_stb(scl_rise_stb), .drive_stb(drive_stb), .sample_stb(sample_stb),
    .stretching(stretching), .busy(busy), .timeout(timeout)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  typedef struct {int h; int w; bit idle_end;} exp_t;
  exp_t sb[$];

  task automatic push_exp(input int h, input int w, input bit idle_end);
    exp_t e;
    e.h = h; e.w = w; e.idle_end = idle_end;
    sb.push_back(e);
  endtask

  // Entered at the negedge where scl_fall_stb is seen; returns at the next fall or idle.
  task automatic run_cycle(input int chg_at, input int chg_val, input int drop_at, input int hold_until);
    int   low_n = 0, drv = -1, rise = -1, smp = -1, str = 0, i = 0;
    bit   idle_end = 0, done = 0;
    exp_t e;
    while (!done) begin
      if (scl_out === 1'b0) low_n++;
      if (drive_stb)    drv  = i;
      if (scl_rise_stb) rise = i;
      if (sample_stb)   smp  = i;
      if (stretching)   str++;
      if (i == chg_at)  half_period = 16'(chg_val);
      if (i == drop_at) enable = 1'b0;
      if (hold_until >= 0 && i == 0) hold_low = 1'b1;
      if (i == hold_until) hold_low = 1'b0;
      @(negedge ref_clk);
      i++;
      if (scl_fall_stb) done = 1;
      else if (!busy) begin done = 1; idle_end = 1; end
      else if (i > 4000) begin check("cycle_bound", i, 0); done = 1; end
    end
    if (sb.size() == 0) begin
      check("sb_underflow", 0, 1);
    end else begin
      e = sb.pop_front();
      check("low_len",     low_n,     e.h);
      check("drive_off",   drv,       e.h / 2);
      check("rise_off",    rise,      e.h + e.w);
      check("sample_off",  smp - rise, e.h / 2);
      check("stretch_len", str,       e.w - 1);
      check("period",      i,         2 * e.h + e.w);
      check("idle_end",    idle_end,  e.idle_end);
    end
  endtask

  initial begin
    int falls;
    reset = 1'b1; enable = 1'b0; hold_low = 1'b0; half_period = 16'd500;
    for (int k = 0; k < 3; k++) begin
      @(negedge ref_clk);
      check("rst_scl_out", scl_out, 1);
      check("rst_busy", busy, 0);
      check("rst_fall", scl_fall_stb, 0);
      check("rst_timeout", timeout, 0);
    end
    reset = 1'b0;
    @(negedge ref_clk);
    check("idle_scl_out", scl_out, 1);
    check("idle_busy", busy, 0);
    enable = 1'b1;
    @(negedge ref_clk);
    check("first_fall", scl_fall_stb, 1);
    check("first_low", scl_out, 0);
    check("first_busy", busy, 1);

    push_exp(500, 1, 0); run_cycle(-1, 0, -1, -1);
    push_exp(500, 1, 0); run_cycle(700, 200, -1, -1);   // change mid-HIGH
    push_exp(200, 1, 0); run_cycle(10, 2, -1, -1);
    push_exp(4, 1, 0);   run_cycle(-1, 0, -1, -1);      // clamped to 4
    push_exp(4, 20, 0);  run_cycle(2, 500, -1, 23);     // 20-cycle stretch
    push_exp(500, 1, 1); run_cycle(-1, 0, 100, -1);     // drop enable mid-LOW

    check("stop_busy", busy, 0);
    check("stop_scl_out", scl_out, 1);
    falls = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge ref_clk);
      if (scl_fall_stb) falls++;
    end
    check("stop_no_fall", falls, 0);

    enable = 1'b1;
    @(negedge ref_clk);
    for (int k = 0; k < 10; k++) @(negedge ref_clk);
    check("midlow_scl_out", scl_out, 0);
    reset = 1'b1;
    @(negedge ref_clk);
    check("abort_scl_out", scl_out, 1);
    check("abort_busy", busy, 0);
    reset = 1'b0; enable = 1'b0;
    @(negedge ref_clk);

`ifdef I2C_SCL_STRETCH_TIMEOUT_EN
    half_period = 16'd4; hold_low = 1'b1; enable = 1'b1;
    @(negedge ref_clk);
    check("to_fall", scl_fall_stb, 1);
    for (int k = 0; k < 67; k++) @(negedge ref_clk);
    check("to_pre_flag", timeout, 0);
    check("to_pre_stretch", stretching, 1);
    check("to_pre_busy", busy, 1);
    @(negedge ref_clk);
    check("to_flag", timeout, 1);
    check("to_busy", busy, 0);
    check("to_scl_out", scl_out, 1);
    check("to_stretch", stretching, 0);
    hold_low = 1'b0;
    falls = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge ref_clk);
      if (scl_fall_stb) falls++;
    end
    check("to_hold_idle", falls, 0);
    check("to_sticky", timeout, 1);
    enable = 1'b0;
    @(negedge ref_clk);
    check("to_clear", timeout, 0);
`else
    half_period = 16'd4; hold_low = 1'b1; enable = 1'b1;
    for (int k = 0; k < 100; k++) @(negedge ref_clk);
    check("nt_stretch", stretching, 1);
    check("nt_busy", busy, 1);
    check("nt_timeout", timeout, 0);
    hold_low = 1'b0; enable = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
